// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode codes and decode helpers shared by the LED pattern generator
// BREATHE decodes only when LED_PATTERN_BREATHE_EN is defined.
package led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF     = 3'b000;
    localparam logic [MODE_W-1:0] MODE_ON      = 3'b001;
    localparam logic [MODE_W-1:0] MODE_BLINK   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_PWM     = 3'b011;
    localparam logic [MODE_W-1:0] MODE_BREATHE = 3'b100;

    // Unknown or disabled codes collapse to OFF so downstream logic sees only legal modes.
    function automatic logic [MODE_W-1:0] mode_decode(input logic [MODE_W-1:0] m);
        logic [MODE_W-1:0] d;
        case (m)
            MODE_ON, MODE_BLINK, MODE_PWM: d = m;
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE:                  d = m;
`endif
            default:                       d = MODE_OFF;
        endcase
        return d;
    endfunction

    function automatic logic uses_blink_cnt(input logic [MODE_W-1:0] d);
        return (d == MODE_BLINK) || (d == MODE_BREATHE);
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - control/status bundle between board logic and the LED generator
// Per-channel fields are packed with channel 0 in the least significant slice.
interface led_pattern_gen_if
    import led_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int CW   = 16,
    parameter int PW   = 8
);
    logic [MODE_W*N_CH-1:0] MODE;
    logic [CW*N_CH-1:0]     HALF_PERIOD;
    logic [PW*N_CH-1:0]     DUTY;
    logic                   SYNC;
    logic                   TICK;
    logic [N_CH-1:0]        LED;

    modport master (
        output MODE, HALF_PERIOD, DUTY, SYNC,
        input  TICK, LED
    );

    modport slave (
        input  MODE, HALF_PERIOD, DUTY, SYNC,
        output TICK, LED
    );
endinterface

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: blink counter/phase, optional breathe level, lit decode
// Breathe level/direction registers exist only when LED_PATTERN_BREATHE_EN is defined.
module led_channel
    import led_pkg::*;
#(
    parameter int CW = 16,
    parameter int PW = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sync,
    input  logic              tick,
    input  logic [MODE_W-1:0] mode,
    input  logic [CW-1:0]     half_period,
    input  logic [PW-1:0]     duty,
    input  logic [PW-1:0]     pwm_cnt,
    output logic              lit
);
    logic [MODE_W-1:0] dmode;
    logic [CW-1:0]     hp_last;
    logic [CW-1:0]     cnt;
    logic              phase;
    logic              running;
    logic              wrap;

    assign dmode   = mode_decode(mode);
    assign running = uses_blink_cnt(dmode);
    // HALF_PERIOD of 0 behaves as 1; ">=" lets a shrinking half-period wrap on the next tick.
    assign hp_last = (half_period == '0) ? '0 : half_period - CW'(1);
    assign wrap    = tick && running && (cnt >= hp_last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (sync || !running) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else if (tick) begin
            cnt   <= cnt + CW'(1);
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    logic [PW-1:0] level;
    logic          dir_down;

    // Triangle ramp: reverse at the end points so each extreme is visited once per sweep.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level    <= '0;
            dir_down <= 1'b0;
        end else if (sync || (dmode != MODE_BREATHE)) begin
            level    <= '0;
            dir_down <= 1'b0;
        end else if (wrap) begin
            if (!dir_down) begin
                if (level == '1) begin
                    level    <= level - PW'(1);
                    dir_down <= 1'b1;
                end else begin
                    level    <= level + PW'(1);
                end
            end else begin
                if (level == '0) begin
                    level    <= level + PW'(1);
                    dir_down <= 1'b0;
                end else begin
                    level    <= level - PW'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        lit = 1'b0;
        case (dmode)
            MODE_ON:      lit = 1'b1;
            MODE_BLINK:   lit = phase;
            MODE_PWM:     lit = (pwm_cnt < duty);
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: lit = (pwm_cnt < level);
`endif
            default:      lit = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver: shared prescaler tick, PWM counter, per-pin polarity
// Optional BREATHE mode is enabled by defining LED_PATTERN_BREATHE_EN.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int              N_CH       = 2,
    parameter int              DIV        = 100000,
    parameter int              CW         = 16,
    parameter int              PW         = 8,
    parameter logic [N_CH-1:0] ACTIVE_LOW = '0
) (
    input  logic             CLK,
    input  logic             RST,
    led_pattern_gen_if.slave bus
);
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRESC_W-1:0] presc;
    logic               presc_end;
    logic               tick;
    logic [PW-1:0]      pwm_cnt;
    logic [N_CH-1:0]    lit;

    assign presc_end = (presc == PRESC_W'(DIV - 1));
    // SYNC wins over a coincident tick so every channel restarts from the same phase.
    assign tick      = presc_end && !bus.SYNC;
    assign bus.TICK  = tick;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (bus.SYNC || presc_end) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_cnt <= '0;
        end else if (bus.SYNC) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_channel #(
            .CW (CW),
            .PW (PW)
        ) u_ch (
            .CLK         (CLK),
            .RST         (RST),
            .sync        (bus.SYNC),
            .tick        (tick),
            .mode        (bus.MODE[g*MODE_W +: MODE_W]),
            .half_period (bus.HALF_PERIOD[g*CW +: CW]),
            .duty        (bus.DUTY[g*PW +: PW]),
            .pwm_cnt     (pwm_cnt),
            .lit         (lit[g])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.LED <= ACTIVE_LOW;
        end else begin
            bus.LED <= lit ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen (DIV=4, CW=4, PW=4, 2 channels)
module tb_led_pattern_gen;

    logic CLK;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    led_pattern_gen_if #(.N_CH(2), .CW(4), .PW(4)) bus ();

    led_pattern_gen #(
        .N_CH       (2),
        .DIV        (4),
        .CW         (4),
        .PW         (4),
        .ACTIVE_LOW (2'b10)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [2:0] m, input logic [3:0] hp, input logic [3:0] dt);
        bus.MODE[ch*3 +: 3]        = m;
        bus.HALF_PERIOD[ch*4 +: 4] = hp;
        bus.DUTY[ch*4 +: 4]        = dt;
    endtask

    // Pulse SYNC from the current falling edge; returns at the falling edge after the sync edge.
    task automatic do_sync();
        bus.SYNC = 1'b1;
        @(negedge CLK);
        bus.SYNC = 1'b0;
    endtask

    task automatic run_pwm(input logic [3:0] dt, input int exp_high);
        int highs;
        highs = 0;
        set_ch(0, 3'b011, 4'd1, dt);
        do_sync();
        for (int k = 2; k <= 33; k++) begin
            @(negedge CLK);
            chk($sformatf("pwm%0d_k%0d", dt, k), bus.LED[0], (((k - 2) % 16) < int'(dt)) ? 1 : 0);
            highs += int'(bus.LED[0]);
        end
        chk($sformatf("pwm%0d_high", dt), highs, exp_high);
    endtask

    initial begin
        RST      = 1'b1;
        bus.SYNC = 1'b0;
        set_ch(0, 3'b001, 4'd0, 4'd0);
        set_ch(1, 3'b001, 4'd0, 4'd0);

        // Reset: all dark with polarity applied, no tick
        repeat (2) @(negedge CLK);
        chk("rst_led", bus.LED, 2'b10);
        chk("rst_tick", bus.TICK, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rel_led", bus.LED, 2'b01);
        chk("rel_tick", bus.TICK, 1'b0);

        // BLINK HP=3: 12 CLK lit / 12 dark, tick every 4 CLK
        set_ch(0, 3'b010, 4'd3, 4'd0);
        set_ch(1, 3'b000, 4'd0, 4'd0);
        do_sync();
        for (int k = 1; k <= 48; k++) begin
            if (k > 1) @(negedge CLK);
            chk($sformatf("blink_tick_k%0d", k), bus.TICK, (k % 4 == 0) ? 1 : 0);
            chk($sformatf("blink_led0_k%0d", k), bus.LED[0],
                ((k == 1) || (((k + 10) / 12) % 2 == 1)) ? 1 : 0);
            chk($sformatf("blink_led1_k%0d", k), bus.LED[1], 1'b1);
        end

        // PWM duty 5, 0, 15
        run_pwm(4'd5, 10);
        run_pwm(4'd0, 0);
        run_pwm(4'd15, 30);

        // Half-period shrink 10 -> 2 while cnt=7
        set_ch(0, 3'b010, 4'd10, 4'd0);
        do_sync();
        for (int k = 2; k <= 50; k++) begin
            @(negedge CLK);
            case (k)
                30, 33, 42, 49: chk($sformatf("shrink_k%0d", k), bus.LED[0], 1'b1);
                34, 41, 50:     chk($sformatf("shrink_k%0d", k), bus.LED[0], 1'b0);
                default: ;
            endcase
            if (k == 30) set_ch(0, 3'b010, 4'd2, 4'd0);
        end

        // SYNC on a TICK cycle with two blinking channels
        set_ch(0, 3'b010, 4'd3, 4'd0);
        set_ch(1, 3'b010, 4'd5, 4'd0);
        do_sync();
        for (int k = 2; k <= 24; k++) @(negedge CLK);
        chk("sync_pre_tick", bus.TICK, 1'b1);
        chk("sync_pre_led", bus.LED, 2'b10);
        bus.SYNC = 1'b1;
        #1;
        chk("sync_tick_masked", bus.TICK, 1'b0);
        @(negedge CLK);
        bus.SYNC = 1'b0;
        chk("sync_post_tick", bus.TICK, 1'b0);
        for (int k = 2; k <= 22; k++) begin
            @(negedge CLK);
            case (k)
                2:  chk("sync_both_lit", bus.LED, 2'b01);
                13: chk("sync_ch0_k13", bus.LED[0], 1'b1);
                14: chk("sync_ch0_k14", bus.LED[0], 1'b0);
                21: chk("sync_ch1_k21", bus.LED[1], 1'b0);
                22: chk("sync_ch1_k22", bus.LED[1], 1'b1);
                default: ;
            endcase
        end

        // MODE 100: breathe ramp when enabled, otherwise dark
        set_ch(0, 3'b100, 4'd1, 4'd9);
        set_ch(1, 3'b000, 4'd0, 4'd0);
        do_sync();
`ifdef LED_PATTERN_BREATHE_EN
        for (int k = 2; k <= 130; k++) begin
            int j;
            int lvl;
            @(negedge CLK);
            j   = ((k - 2) / 4) % 30;
            lvl = (j <= 15) ? j : 30 - j;
            chk($sformatf("breathe_k%0d", k), bus.LED[0], (((k - 2) % 16) < lvl) ? 1 : 0);
        end
`else
        for (int k = 2; k <= 40; k++) begin
            @(negedge CLK);
            chk($sformatf("mode100_dark_k%0d", k), bus.LED, 2'b10);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
